// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : FSM state encoding (IDLE, REQ, WAIT, DRAIN)
//   fault_cause_t : sticky fault reason reported on fault_cause
//   NOP_INSTR     : instruction register contents after reset (addi x0,x0,0)
//   is_aligned()  : word-alignment test on a fetch address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        BUS_ERR    = 2'd2,
        TIMEOUT    = 2'd3
    } fault_cause_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Saturating cycle counter used to bound the wait for a memory response.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   clear   : synchronous clear to zero (wins over enable)
//   enable  : count one cycle
//   expired : count has reached LIMIT-1; the counter holds there, never wraps
// -----------------------------------------------------------------------------
module fetch_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Single-outstanding instruction fetch unit. Takes a fetch request from the
// program counter, issues one memory read, and captures the returned word in
// the instruction register. Misaligned addresses, bus errors and response
// timeouts are reported as one-cycle fault pulses with a sticky cause.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   fetch_start, pc     : fetch request and address (sampled only in IDLE)
//   flush               : abandon the fetch in progress
//   mem_req_valid/ready : request handshake, mem_addr is the request address
//   mem_rsp_valid/data/err : one-cycle response beat, err qualified by valid
//   ir, ir_pc           : last good instruction word and its address
//   fetch_done          : one-cycle pulse after a good response
//   fetch_busy          : high whenever the FSM is not IDLE
//   fetch_fault         : one-cycle pulse on a fault, fault_cause holds reason
//   state_dbg           : current FSM state, for observation only
//
// Handshake: a request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high. While valid is high and ready is low, the
// address is held stable and valid is not withdrawn except by flush.
// Responses carry no backpressure: mem_rsp_valid is a single-cycle beat that
// is consumed in the cycle it is seen.
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fetch_start,
    input  logic [31:0]  pc,
    input  logic         flush,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_addr,
    input  logic         mem_rsp_valid,
    input  logic [31:0]  mem_rsp_data,
    input  logic         mem_rsp_err,
    output logic [31:0]  ir,
    output logic [31:0]  ir_pc,
    output logic         fetch_done,
    output logic         fetch_busy,
    output logic         fetch_fault,
    output fault_cause_t fault_cause,
    output fetch_state_t state_dbg
);

    fetch_state_t state_q, state_nxt;
    logic [31:0]  addr_q,  addr_nxt;
    logic [31:0]  ir_q,    ir_nxt;
    logic [31:0]  ir_pc_q, ir_pc_nxt;
    logic         done_q,  done_nxt;
    logic         fault_q, fault_nxt;
    fault_cause_t cause_q, cause_nxt;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // The counter only runs while waiting for a response; it is held at zero
    // everywhere else, so it always starts fresh on the REQ->WAIT transfer.
    assign timer_clear  = (state_q != WAIT);
    assign timer_enable = (state_q == WAIT);

    fetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= RESET_VECTOR;
            ir_q    <= NOP_INSTR;
            ir_pc_q <= RESET_VECTOR;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= NONE;
        end else begin
            state_q <= state_nxt;
            addr_q  <= addr_nxt;
            ir_q    <= ir_nxt;
            ir_pc_q <= ir_pc_nxt;
            done_q  <= done_nxt;
            fault_q <= fault_nxt;
            cause_q <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        ir_nxt    = ir_q;
        ir_pc_nxt = ir_pc_q;
        done_nxt  = 1'b0;
        fault_nxt = 1'b0;
        cause_nxt = cause_q;

        case (state_q)
            IDLE: begin
                // flush dominates a simultaneous start
                if (fetch_start && !flush) begin
                    if (is_aligned(pc)) begin
                        addr_nxt  = pc;
                        state_nxt = REQ;
                    end else begin
                        fault_nxt = 1'b1;
                        cause_nxt = MISALIGNED;
                    end
                end
            end

            REQ: begin
                if (flush) begin
                    // A request accepted in the flush cycle still owes us a
                    // response, which must be swallowed.
                    state_nxt = mem_req_ready ? DRAIN : IDLE;
                end else if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (flush) begin
                    // A response landing in the flush cycle settles the debt.
                    state_nxt = mem_rsp_valid ? IDLE : DRAIN;
                end else if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                    if (mem_rsp_err) begin
                        fault_nxt = 1'b1;
                        cause_nxt = BUS_ERR;
                    end else begin
                        ir_nxt    = mem_rsp_data;
                        ir_pc_nxt = addr_q;
                        done_nxt  = 1'b1;
                    end
                end else if (timer_expired) begin
                    // Memory still owes the response; drain it before reuse.
                    fault_nxt = 1'b1;
                    cause_nxt = TIMEOUT;
                    state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q;
    assign ir            = ir_q;
    assign ir_pc         = ir_pc_q;
    assign fetch_done    = done_q;
    assign fetch_fault   = fault_q;
    assign fault_cause   = cause_q;
    assign fetch_busy    = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch: a table of single fetches with hand-computed
// results, followed by hand-written sequences for flush, timeout/drain and
// reset-during-fetch behaviour.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import fetch_pkg::*;

    logic         clk;
    logic         reset;
    logic         fetch_start;
    logic [31:0]  pc;
    logic         flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_addr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         mem_rsp_err;
    logic [31:0]  ir;
    logic [31:0]  ir_pc;
    logic         fetch_done;
    logic         fetch_busy;
    logic         fetch_fault;
    fault_cause_t fault_cause;
    fetch_state_t state_dbg;

    instr_fetch #(
        .RESET_VECTOR   (32'h0000_1000),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_start   (fetch_start),
        .pc            (pc),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .fetch_done    (fetch_done),
        .fetch_busy    (fetch_busy),
        .fetch_fault   (fetch_fault),
        .fault_cause   (fault_cause),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- monitor (counts only) ----------------
    int done_cnt    = 0;
    int fault_cnt   = 0;
    int hs_cnt      = 0;
    int overlap_cnt = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (fetch_done) begin
            done_cnt++;
            obs_q.push_back(ir);
        end
        if (fetch_fault) fault_cnt++;
        if (fetch_done && fetch_fault) overlap_cnt++;
        if (mem_req_valid && mem_req_ready) hs_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Compare every captured done-word against the expected queue.
    task automatic scoreboard_drain(input string name);
        logic [31:0] o;
        logic [31:0] e;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_sb_ir"}, o, e);
        end
        check({name, "_sb_obs_left"}, 32'(obs_q.size()), 32'd0);
        check({name, "_sb_exp_left"}, 32'(exp_q.size()), 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_fetch(input logic [31:0] a);
        fetch_start = 1'b1;
        pc          = a;
        tick();
        fetch_start = 1'b0;
        pc          = ~a;   // address must have been latched
    endtask

    task automatic send_rsp(input logic [31:0] d, input logic e);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        mem_rsp_err   = e;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = 32'h0;
    endtask

    // One complete fetch with request backpressure and response latency.
    task automatic do_fetch(input string name, input logic [31:0] a, input int rdy_dly,
                            input int rsp_dly, input logic [31:0] d, input logic e);
        start_fetch(a);
        if (a[1:0] != 2'b00) begin
            check({name, "_no_req"}, {31'd0, mem_req_valid}, 32'd0);
            tick();
            tick();
            return;
        end
        for (int c = 0; c < rdy_dly; c++) begin
            check({name, "_req_valid_hold"}, {31'd0, mem_req_valid}, 32'd1);
            check({name, "_addr_hold"}, mem_addr, a);
            tick();
        end
        check({name, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        check({name, "_addr"}, mem_addr, a);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int c = 0; c < rsp_dly; c++) begin
            // start while busy must be ignored
            fetch_start = 1'b1;
            pc          = a + 32'h100;
            tick();
        end
        fetch_start = 1'b0;
        send_rsp(d, e);
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] pc;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] data;
        logic        err;
        int          exp_done;
        int          exp_fault;
        int          exp_hs;
        logic [1:0]  exp_cause;
        logic [31:0] exp_ir;
        logic [31:0] exp_ir_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, f0, h0;
        int n;
        logic [31:0] ir_keep;

        fetch_start   = 1'b0;
        pc            = 32'h0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        reset         = 1'b0;

        vecs[0] = '{32'h0000_1000, 0, 3,  32'h0050_0093, 1'b0, 1, 0, 1, 2'd0, 32'h0050_0093, 32'h0000_1000};
        vecs[1] = '{32'h0000_1002, 0, 0,  32'h0,         1'b0, 0, 1, 0, 2'd1, 32'h0050_0093, 32'h0000_1000};
        vecs[2] = '{32'h0000_2004, 5, 0,  32'h1234_5678, 1'b0, 1, 0, 1, 2'd1, 32'h1234_5678, 32'h0000_2004};
        vecs[3] = '{32'h0000_3008, 0, 5,  32'hCAFE_F00D, 1'b1, 0, 1, 1, 2'd2, 32'h1234_5678, 32'h0000_2004};
        vecs[4] = '{32'h0000_4001, 0, 0,  32'h0,         1'b0, 0, 1, 0, 2'd1, 32'h1234_5678, 32'h0000_2004};
        vecs[5] = '{32'h0000_400C, 1, 1,  32'h00A0_0113, 1'b0, 1, 0, 1, 2'd1, 32'h00A0_0113, 32'h0000_400C};
        vecs[6] = '{32'h0000_5003, 0, 0,  32'h0,         1'b0, 0, 1, 0, 2'd1, 32'h00A0_0113, 32'h0000_400C};
        vecs[7] = '{32'h0000_500C, 0, 10, 32'h0040_0193, 1'b1, 0, 1, 1, 2'd2, 32'h00A0_0113, 32'h0000_400C};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",  32'(state_dbg), 32'(IDLE));
        check("rst_ir",     ir, 32'h0000_0013);
        check("rst_ir_pc",  ir_pc, 32'h0000_1000);
        check("rst_addr",   mem_addr, 32'h0000_1000);
        check("rst_cause",  32'(fault_cause), 32'd0);
        check("rst_valid",  {31'd0, mem_req_valid}, 32'd0);
        check("rst_busy",   {31'd0, fetch_busy}, 32'd0);
        reset = 1'b1;
        tick();

        // table-driven single fetches
        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            d0 = done_cnt;
            f0 = fault_cnt;
            h0 = hs_cnt;
            if (vecs[i].exp_done != 0) exp_q.push_back(vecs[i].exp_ir);
            do_fetch(nm, vecs[i].pc, vecs[i].rdy_dly, vecs[i].rsp_dly, vecs[i].data, vecs[i].err);
            check({nm, "_done_pulses"},  32'(done_cnt - d0),  32'(vecs[i].exp_done));
            check({nm, "_fault_pulses"}, 32'(fault_cnt - f0), 32'(vecs[i].exp_fault));
            check({nm, "_handshakes"},   32'(hs_cnt - h0),    32'(vecs[i].exp_hs));
            check({nm, "_cause"},        32'(fault_cause),    {30'd0, vecs[i].exp_cause});
            check({nm, "_ir"},           ir,                  vecs[i].exp_ir);
            check({nm, "_ir_pc"},        ir_pc,               vecs[i].exp_ir_pc);
            check({nm, "_idle"},         32'(state_dbg),      32'(IDLE));
            scoreboard_drain(nm);
        end

        // flush in REQ with ready low, third cycle of backpressure
        ir_keep = ir;
        d0 = done_cnt; f0 = fault_cnt; h0 = hs_cnt;
        start_fetch(32'h0000_7000);
        for (int c = 0; c < 2; c++) begin
            check("flreq_addr_hold", mem_addr, 32'h0000_7000);
            tick();
        end
        check("flreq_addr_c3", mem_addr, 32'h0000_7000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flreq_state", 32'(state_dbg), 32'(IDLE));
        check("flreq_valid", {31'd0, mem_req_valid}, 32'd0);
        tick();
        check("flreq_done",  32'(done_cnt - d0),  32'd0);
        check("flreq_fault", 32'(fault_cnt - f0), 32'd0);
        check("flreq_hs",    32'(hs_cnt - h0),    32'd0);
        check("flreq_ir",    ir, ir_keep);

        // flush dominates start in IDLE
        h0 = hs_cnt;
        flush = 1'b1;
        start_fetch(32'h0000_7100);
        flush = 1'b0;
        check("flidle_state", 32'(state_dbg), 32'(IDLE));
        tick();
        check("flidle_hs", 32'(hs_cnt - h0), 32'd0);

        // flush in REQ together with ready: accepted request is drained
        d0 = done_cnt; f0 = fault_cnt;
        start_fetch(32'h0000_7200);
        flush = 1'b1;
        mem_req_ready = 1'b1;
        tick();
        flush = 1'b0;
        mem_req_ready = 1'b0;
        check("flrdy_state", 32'(state_dbg), 32'(DRAIN));
        check("flrdy_busy",  {31'd0, fetch_busy}, 32'd1);
        send_rsp(32'hBAD0_0001, 1'b0);
        check("flrdy_idle", 32'(state_dbg), 32'(IDLE));
        tick();
        check("flrdy_ir",    ir, ir_keep);
        check("flrdy_done",  32'(done_cnt - d0),  32'd0);
        check("flrdy_fault", 32'(fault_cnt - f0), 32'd0);

        // flush in WAIT without response -> DRAIN; with response -> IDLE
        start_fetch(32'h0000_7300);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flwait_state", 32'(state_dbg), 32'(DRAIN));
        send_rsp(32'hBAD0_0002, 1'b0);
        check("flwait_idle", 32'(state_dbg), 32'(IDLE));
        start_fetch(32'h0000_7400);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        send_rsp(32'hBAD0_0003, 1'b0);
        flush = 1'b0;
        check("flwrsp_state", 32'(state_dbg), 32'(IDLE));
        tick();
        check("flwait_ir",    ir, ir_keep);
        check("flwait_done",  32'(done_cnt - d0),  32'd0);
        check("flwait_fault", 32'(fault_cnt - f0), 32'd0);

        // timeout after 64 WAIT cycles, then the late response is drained
        d0 = done_cnt; f0 = fault_cnt;
        start_fetch(32'h0000_8000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        n = 0;
        while (!fetch_fault && n < 200) begin
            tick();
            n++;
        end
        check("to_wait_cycles", 32'(n), 32'd64);
        check("to_cause", 32'(fault_cause), 32'd3);
        check("to_state", 32'(state_dbg), 32'(DRAIN));
        repeat (3) tick();
        check("to_drain_hold", 32'(state_dbg), 32'(DRAIN));
        send_rsp(32'hDEAD_BEEF, 1'b0);
        check("to_drain_idle", 32'(state_dbg), 32'(IDLE));
        tick();
        check("to_ir",    ir, ir_keep);
        check("to_done",  32'(done_cnt - d0),  32'd0);
        check("to_fault", 32'(fault_cnt - f0), 32'd1);
        check("to_cause_held", 32'(fault_cause), 32'd3);

        // reset in the middle of WAIT; the stale response must be ignored
        start_fetch(32'h0000_9000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rstw_state", 32'(state_dbg), 32'(IDLE));
        check("rstw_ir",    ir, 32'h0000_0013);
        check("rstw_ir_pc", ir_pc, 32'h0000_1000);
        check("rstw_addr",  mem_addr, 32'h0000_1000);
        check("rstw_cause", 32'(fault_cause), 32'd0);
        check("rstw_valid", {31'd0, mem_req_valid}, 32'd0);
        tick();
        reset = 1'b1;
        d0 = done_cnt; f0 = fault_cnt;
        send_rsp(32'hBAD0_0004, 1'b0);
        tick();
        check("stale_state", 32'(state_dbg), 32'(IDLE));
        check("stale_ir",    ir, 32'h0000_0013);
        check("stale_done",  32'(done_cnt - d0),  32'd0);
        check("stale_fault", 32'(fault_cnt - f0), 32'd0);

        // good fetch after reset still works
        exp_q.push_back(32'h0010_0213);
        do_fetch("post", 32'h0000_A000, 0, 2, 32'h0010_0213, 1'b0);
        check("post_ir",    ir, 32'h0010_0213);
        check("post_ir_pc", ir_pc, 32'h0000_A000);
        scoreboard_drain("post");

        check("done_fault_overlap", 32'(overlap_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_1000, SHALL be the ir_pc value after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL be the maximum cycles in WAIT before a timeout fault.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_start  input  1  SHALL request a fetch at pc; sampled only in IDLE.
REQ-006 pc  input  32  SHALL be the fetch address from the program counter, sampled with fetch_start.
REQ-007 flush  input  1  SHALL abandon any fetch in progress.
REQ-008 mem_req_valid  output  1  SHALL flag a valid read request.
REQ-009 mem_req_ready  input  1  SHALL be the memory's acceptance of the request.
REQ-010 mem_addr  output  32  SHALL be the request address.
REQ-011 mem_rsp_valid  input  1  SHALL flag response data valid (one cycle per response).
REQ-012 mem_rsp_data  input  32  SHALL be the instruction word.
REQ-013 mem_rsp_err  input  1  SHALL flag a bus error, qualified by mem_rsp_valid.
REQ-014 ir  output  32  SHALL be the last successfully fetched instruction.
REQ-015 ir_pc  output  32  SHALL be the address of ir.
REQ-016 fetch_done  output  1  SHALL be a one-cycle pulse on successful completion.
REQ-017 fetch_busy  output  1  SHALL be high in any state other than IDLE.
REQ-018 fetch_fault  output  1  SHALL be a one-cycle pulse on fault; fault_cause  output  2  SHALL be held until the next fault or reset.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, DRAIN.
REQ-020 IDLE with fetch_start=1, flush=0, pc[1:0]=0: latch pc into an address register; go to REQ next cycle.
REQ-021 IDLE with fetch_start=1, flush=0, pc[1:0]!=0: no request; pulse fetch_fault next cycle; set fault_cause=MISALIGNED; stay IDLE.
REQ-022 In REQ, mem_req_valid SHALL be 1 and mem_addr SHALL equal the latched address, held stable until mem_req_ready=1.
REQ-023 REQ with mem_req_ready=1 SHALL go to WAIT and clear the timeout counter.
REQ-024 WAIT with mem_rsp_valid=1, mem_rsp_err=0: load ir=mem_rsp_data and ir_pc=latched address; pulse fetch_done in the cycle after; go to IDLE.
REQ-025 WAIT with mem_rsp_valid=1, mem_rsp_err=1: ir and ir_pc unchanged; pulse fetch_fault; set fault_cause=BUS_ERR; go to IDLE.
REQ-026 WAIT with the counter reaching TIMEOUT_CYCLES-1 and no response: pulse fetch_fault; set fault_cause=TIMEOUT; go to DRAIN.
REQ-027 flush in IDLE SHALL dominate fetch_start; no request is issued.
REQ-028 flush in REQ with mem_req_ready=0 SHALL go to IDLE; with mem_req_ready=1 the handshake counts and the FSM goes to DRAIN.
REQ-029 flush in WAIT SHALL go to DRAIN; if mem_rsp_valid=1 in the same cycle, that response is discarded and the FSM goes to IDLE.
REQ-030 DRAIN SHALL discard exactly one response (no ir update, no done, no fault), then go to IDLE.
REQ-031 fetch_start outside IDLE SHALL be ignored; there is at most one outstanding request.
REQ-032 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-033 fetch_done and fetch_fault SHALL never be high in the same cycle.

Reset
REQ-034 Asserting reset SHALL, at any time: force IDLE; set mem_req_valid=0, fetch_done=0, fetch_fault=0, fault_cause=NONE, ir=32'h0000_0013 (NOP), ir_pc=RESET_VECTOR, mem_addr=RESET_VECTOR; clear the counter.
REQ-035 A response arriving after reset is released, for a request issued before reset, SHALL be ignored.

Structure
REQ-036 Package fetch_pkg SHALL hold the state enum, the fault_cause enum (NONE=0, MISALIGNED=1, BUS_ERR=2, TIMEOUT=3) and the NOP constant.
REQ-037 The timeout counter SHALL be a sub-module named fetch_timer (clear, enable, expired).

Verification
REQ-038 pc=0x1000, fetch_start=1; ready at once; rsp 3 cycles later, data=0x00500093 -> ir=0x00500093, ir_pc=0x1000, one fetch_done pulse.
REQ-039 pc=0x1002, fetch_start=1 -> no mem_req_valid, fetch_fault pulse, fault_cause=1.
REQ-040 ready held low 5 cycles -> mem_addr stable for all 5 cycles; flush in cycle 3 -> IDLE, no done, no fault.
REQ-041 rsp never arrives -> fault_cause=3 after 64 WAIT cycles; a later response with data 0xDEADBEEF is discarded and ir is unchanged.
REQ-042 rsp_err=1 -> fault_cause=2, ir unchanged; reset mid-WAIT -> ir=0x00000013, ir_pc=0x1000.
